// File: rtl/mux64_rr_arbiter_if.sv
// Handshake bundle for mux64_rr_arbiter: two requesters, one output, status.
// Defining ARB_LOCK_EN adds the per-port lock inputs.
`timescale 1ns/1ps
interface mux64_rr_arbiter_if #(
  parameter int W     = 64,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic [W-1:0]     req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [W-1:0]     req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_src;
  logic             out_ready;
  logic             sel;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`ifdef ARB_LOCK_EN
  logic             req0_lock;
  logic             req1_lock;
`endif

  modport slave (
`ifdef ARB_LOCK_EN
    input  req0_lock, req1_lock,
`endif
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_src,
    output sel, cnt0, cnt1
  );

  modport master (
`ifdef ARB_LOCK_EN
    output req0_lock, req1_lock,
`endif
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_src,
    input  sel, cnt0, cnt1
  );
endinterface

// File: rtl/mux64_rr_arbiter.sv
// Two-port round-robin 64-bit arbiter with a one-entry registered output.
// Optional macro ARB_LOCK_EN: a granted beat may lock the port until released.
`timescale 1ns/1ps
module mux64_rr_arbiter #(
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  mux64_rr_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             last;
  logic             sel;
  logic             space;
  logic             acc0;
  logic             acc1;
  logic             acc;
  logic [W-1:0]     data_q;
  logic             src_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
`ifdef ARB_LOCK_EN
  logic             locked;
  logic             owner;
`endif

  assign space = (state == EMPTY) | bus.out_ready;

  always_comb begin
    sel = last;
    unique case (1'b1)
      bus.req0_valid & bus.req1_valid:  sel = ~last;
      bus.req0_valid & ~bus.req1_valid: sel = 1'b0;
      ~bus.req0_valid & bus.req1_valid: sel = 1'b1;
      default:                          sel = last;
    endcase
`ifdef ARB_LOCK_EN
    if (locked) sel = owner;
`endif
  end

  assign acc0 = space & bus.req0_valid & ~sel & ~rst;
  assign acc1 = space & bus.req1_valid & sel & ~rst;
  assign acc  = acc0 | acc1;

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.sel        = sel;
  assign bus.out_valid  = (state == FULL);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      src_q  <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      last   <= 1'b1;
`ifdef ARB_LOCK_EN
      locked <= 1'b0;
      owner  <= 1'b0;
`endif
    end else begin
      unique case (state)
        EMPTY: if (acc) state <= FULL;
        FULL:  if (!acc && bus.out_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (acc) begin
        data_q <= sel ? bus.req1_data : bus.req0_data;
        src_q  <= sel;
        last   <= sel;
`ifdef ARB_LOCK_EN
        // An owner beat with lock low is still granted, then releases.
        locked <= sel ? bus.req1_lock : bus.req0_lock;
        owner  <= sel;
`endif
      end
      if (acc0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (acc1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mux64_rr_arbiter.sv
// Scenario bench for mux64_rr_arbiter with a scoreboard of expected
// output words; inputs change 1ns after posedge, outputs sampled at negedge.
`timescale 1ns/1ps
module tb_mux64_rr_arbiter;
  localparam int W     = 64;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [W:0] sb[$];
  logic [W:0] exp_w;

  mux64_rr_arbiter_if #(.W(W), .CNT_W(CNT_W)) bus ();

  mux64_rr_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty got src=%b data=%h, no word expected",
                 bus.out_src, bus.out_data);
      end else begin
        exp_w = sb.pop_front();
        if ({bus.out_src, bus.out_data} !== exp_w) begin
          n_fail++;
          $display("FAIL sb_word got src=%b data=%h exp src=%b data=%h",
                   bus.out_src, bus.out_data, exp_w[W], exp_w[W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    bus.out_ready  = 1'b1;
`ifdef ARB_LOCK_EN
    bus.req0_lock  = 1'b0;
    bus.req1_lock  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready got %b%b exp 00",
               bus.req0_ready, bus.req1_ready);
    end
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out got v=%b d=%h s=%b exp 0/0/0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    n_chk++;
    if (bus.cnt0 !== '0 || bus.cnt1 !== '0) begin
      n_fail++;
      $display("FAIL rst_cnt got %h/%h exp 0/0", bus.cnt0, bus.cnt1);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    sb.delete();
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    d = 64'h0123_4567_89AB_CDEF;
    bus.req0_valid = 1'b1;
    bus.req0_data  = d;
    bus.out_ready  = 1'b1;
    sb.push_back({1'b0, d});
    @(negedge clk);
    n_chk++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0 ||
        bus.sel !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready got r=%b%b sel=%b exp r=10 sel=0",
               bus.req0_ready, bus.req1_ready, bus.sel);
    end
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== d ||
        bus.out_src !== 1'b0 || bus.cnt0 !== 16'd1) begin
      n_fail++;
      $display("FAIL single_out got v=%b d=%h s=%b c0=%0d exp 1/%h/0/1",
               bus.out_valid, bus.out_data, bus.out_src, bus.cnt0, d);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain got v=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_tie();
    logic [W-1:0] da;
    logic [W-1:0] d5;
    logic [3:0]   g;
    da = 64'hAAAA_AAAA_AAAA_AAAA;
    d5 = 64'h5555_5555_5555_5555;
    g  = 4'b1010;
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = da;
    bus.req1_valid = 1'b1;
    bus.req1_data  = d5;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(g[i] ? {1'b1, d5} : {1'b0, da});
      @(negedge clk);
      if (i > 0) begin
        n_chk++;
        if (bus.out_src !== g[i-1]) begin
          n_fail++;
          $display("FAIL tie_src%0d got %b exp %b", i-1, bus.out_src, g[i-1]);
        end
      end
      n_chk++;
      if (bus.sel !== g[i] || bus.req0_ready !== ~g[i] ||
          bus.req1_ready !== g[i]) begin
        n_fail++;
        $display("FAIL tie_sel%0d got sel=%b r=%b%b exp sel=%b",
                 i, bus.sel, bus.req0_ready, bus.req1_ready, g[i]);
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_src !== 1'b1 || bus.cnt0 !== 16'd2 || bus.cnt1 !== 16'd2) begin
      n_fail++;
      $display("FAIL tie_end got s=%b c0=%0d c1=%0d exp 1/2/2",
               bus.out_src, bus.cnt0, bus.cnt1);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0;
    logic [W-1:0] d0b;
    logic [W-1:0] d1;
    d0  = 64'h1111_1111_1111_1111;
    d0b = 64'h3333_3333_3333_3333;
    d1  = 64'h2222_2222_2222_2222;
    bus.out_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = d0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = d1;
    sb.push_back({1'b0, d0});
    tick();
    bus.req0_data = d0b;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          bus.out_valid !== 1'b1 || bus.out_data !== d0) begin
        n_fail++;
        $display("FAIL bp_stall%0d got r=%b%b v=%b d=%h exp r=00 v=1 d=%h",
                 i, bus.req0_ready, bus.req1_ready, bus.out_valid,
                 bus.out_data, d0);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got r=%b%b exp 01",
               bus.req0_ready, bus.req1_ready);
    end
    sb.push_back({1'b1, d1});
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 1'b1 ||
        bus.out_data !== d1 || bus.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overwrite got v=%b s=%b d=%h r0=%b exp 1/1/%h/1",
               bus.out_valid, bus.out_src, bus.out_data, bus.req0_ready, d1);
    end
    sb.push_back({1'b0, d0b});
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_data !== d0b || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_b2b got v=%b d=%h exp 1/%h",
               bus.out_valid, bus.out_data, d0b);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 64'hC0C0_C0C0_0000_0001;
    sb.push_back({1'b0, 64'hC0C0_C0C0_0000_0001});
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.req1_data = {32'hB0B0_0000, 32'(i)};
      sb.push_back({1'b1, 32'hB0B0_0000, 32'(i)});
      tick();
    end
    bus.req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.cnt1 !== 16'hFFFF || bus.cnt0 !== 16'd1) begin
      n_fail++;
      $display("FAIL wrap_full got c1=%h c0=%h exp FFFF/0001",
               bus.cnt1, bus.cnt0);
    end
    tick();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 64'hDEAD_BEEF_0000_FFFF;
    sb.push_back({1'b1, 64'hDEAD_BEEF_0000_FFFF});
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.cnt1 !== 16'h0000 || bus.cnt0 !== 16'd1) begin
      n_fail++;
      $display("FAIL wrap_zero got c1=%h c0=%h exp 0000/0001",
               bus.cnt1, bus.cnt0);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req0_data = 64'h5000 + 64'(i);
      sb.push_back({1'b0, 64'h5000 + 64'(i)});
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.cnt0 !== 16'd5) begin
      n_fail++;
      $display("FAIL mr_pre got v=%b c0=%0d exp 1/5",
               bus.out_valid, bus.cnt0);
    end
    tick();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 64'h7777_0000_0000_0000;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 64'h8888_0000_0000_0000;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_ready got %b%b exp 00",
               bus.req0_ready, bus.req1_ready);
    end
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.cnt0 !== '0 || bus.cnt1 !== '0) begin
      n_fail++;
      $display("FAIL mr_post got v=%b c0=%0d c1=%0d exp 0/0/0",
               bus.out_valid, bus.cnt0, bus.cnt1);
    end
    n_chk++;
    if (bus.sel !== 1'b0 || bus.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_tie got sel=%b r0=%b exp 0/1",
               bus.sel, bus.req0_ready);
    end
    sb.push_back({1'b0, 64'h7777_0000_0000_0000});
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_src !== 1'b0 || bus.out_data !== 64'h7777_0000_0000_0000) begin
      n_fail++;
      $display("FAIL mr_word got s=%b d=%h exp 0/7777000000000000",
               bus.out_src, bus.out_data);
    end
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [2:0] lk;
    lk = 3'b011;
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_lock  = 1'b1;
    bus.req1_data  = 64'hF00D_0000_0000_0000;
    sb.push_back({1'b1, 64'hF00D_0000_0000_0000});
    @(negedge clk);
    n_chk++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_first got r1=%b exp 1", bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 64'hA0A0_0000_0000_0000;
    for (int i = 0; i < 3; i++) begin
      bus.req1_lock = lk[i];
      bus.req1_data = 64'hF00D_0000_0000_0001 + 64'(i);
      sb.push_back({1'b1, 64'hF00D_0000_0000_0001 + 64'(i)});
      @(negedge clk);
      n_chk++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1 ||
          bus.out_src !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_beat%0d got r=%b%b s=%b exp r=01 s=1",
                 i, bus.req0_ready, bus.req1_ready, bus.out_src);
      end
      tick();
    end
    bus.req1_valid = 1'b0;
    bus.req1_lock  = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.req0_ready !== 1'b1 || bus.out_src !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_release got r0=%b s=%b exp 1/1",
               bus.req0_ready, bus.out_src);
    end
    sb.push_back({1'b0, 64'hA0A0_0000_0000_0000});
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_after got s=%b exp 0", bus.out_src);
    end
    tick();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_wrap();
    test_mid_reset();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    tick();
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d words exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux64_rr_arbiter.md
Name: mux64_rr_arbiter

Overview:
- Shares one 64-bit datapath between two requesters through a 2:1 64-bit select stage.
- Arbitrates per beat using round-robin, drives the select, and registers the chosen word into a one-entry output stage with valid/ready handshakes on every side.
- Sits in front of a shared 64-bit consumer, such as a memory write port or a writeback bus, in the datapath.

Parameters:
- W, 64, data width of each requester and of the output.
- CNT_W, 16, width of the per-port accepted-beat counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  W  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  W  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered word.
- out_src  out  1  source of out_data (0 = req0, 1 = req1).
- out_ready  in  1  consumer accepts out_data.
- sel  out  1  combinational select for the current cycle (0 = I0/req0, 1 = I1/req1).
- cnt0  out  CNT_W  beats accepted from req0.
- cnt1  out  CNT_W  beats accepted from req1.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_src=0, cnt0=cnt1=0.
  - Round-robin pointer last=1, so req0 wins the first tie.
  - Reset mid-operation discards the held word; no handshake completes in the reset cycle (req0_ready=req1_ready=0 while rst=1).
- Space: space = ~out_valid | out_ready.
- Select, combinational:
  - Both valid: sel = ~last.
  - Only reqN valid: sel = N.
  - Neither valid: sel = last (holds, no transfer).
- Ready:
  - reqN_ready = space & reqN_valid & (sel==N) & ~rst.
  - At most one ready is high per cycle.
  - Requesters must not wait for ready before asserting valid.
  - Once asserted, valid and data are held until accepted.
- Accept (reqN_valid & reqN_ready):
  - out_data <= selected word, out_src <= N, out_valid <= 1.
  - last <= N.
  - cntN <= cntN+1, wrapping at 2^CNT_W-1 -> 0.
- Drain: if out_valid & out_ready and no accept this cycle, out_valid <= 0; out_data and out_src hold their stale value.
- Simultaneous drain and accept: the register is overwritten with the new word and out_valid stays 1, giving full throughput of 1 beat/cycle.
- Back-pressure: out_valid=1 and out_ready=0 -> no ready asserted; out_data/out_src stable; last is unchanged.
- Latency: a word accepted at edge k is visible on out_data after edge k; minimum 1 cycle.
- Fairness: with both requesters continuously valid and the consumer always ready, grants alternate 0,1,0,1...
- State machine (2 states):
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept, or on stall (out_ready=0).
  - FULL -> EMPTY on drain without accept.
  - Any state -> EMPTY on rst.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - Adds inputs req0_lock and req1_lock (1 bit each), sampled with the accepted beat.
  - An accept from port N with reqN_lock=1 sets locked=1 and owner=N.
  - While locked, sel=owner regardless of the other port's valid; the other port's ready stays 0.
  - Lock is released by an owner accept with lock=0 (that beat is still granted), or by rst.
  - Reset value of locked is 0.
- Undefined: no lock ports; pure per-beat round-robin as above.

Test Plan:
- Reset then single requester: req0_valid=1, data=64'h0123_4567_89AB_CDEF, out_ready=1 -> req0_ready=1 in cycle 1; next cycle out_valid=1, out_data=64'h0123_4567_89AB_CDEF, out_src=0, cnt0=1.
- Tie after reset: both valid, data 64'hAAAA... and 64'h5555..., out_ready=1 held for 4 cycles -> out_src sequence 0,1,0,1; cnt0=cnt1=2.
- Back-pressure: out_valid=1 with out_ready=0 for 3 cycles while both request -> req*_ready=0, out_data stable; first ready cycle drains and accepts simultaneously, out_valid stays 1.
- Counter wrap: preload via 65535 req1 beats -> cnt1=16'hFFFF; one more beat -> cnt1=0, cnt0 unchanged.
- Mid-operation reset: out_valid=1, cnt0=5; assert rst for 1 cycle with both valid -> req*_ready=0 that cycle; afterwards out_valid=0, cnt0=0, next tie is granted to req0.
- ARB_LOCK_EN: req1 accepted with lock=1, then req0 and req1 both valid for 3 beats with req1_lock=1,1,0 -> out_src=1,1,1 then 0; req0_ready=0 until the unlock beat completes.
